debounce_moore: RTL and testbench

Synchronous input conditioner that sits directly upstream of the edge detector in the `simple_fsm` chain. It optionally re-times a raw asynchronous level through a two-flop synchronizer, then qualifies that level with a Moore FSM plus stability counter. It presents a glitch-free debounced level on `o_q`; that output drives the edge detector's `in_i`.

---
 rtl/debounce_moore.sv | 111 +++++++++++
 tb/tb_debounce_moore.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_moore.sv
// Debounce conditioner: optional two-flop synchronizer (DEBOUNCE_SYNC_EN) feeding a
// four-state Moore FSM that accepts a new level after STABLE_CYCLES identical samples.
module debounce_moore #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_i,
    output logic o_q,
    output logic o_busy
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    logic sync1_reg, sync2_reg;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= in_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg;
`else
    assign s = in_i;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg <= IDLE_LO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The IDLE sample counts as the first of the STABLE_CYCLES, hence cnt starts at 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE_LO: begin
                if (s) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_q    = (state_reg == IDLE_HI) || (state_reg == WAIT_LO);
        o_busy = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);
    end

endmodule

// File: tb/tb_debounce_moore.sv
// Directed bench for debounce_moore with STABLE_CYCLES=4; table of per-cycle vectors
// plus hand-written reset-mid-qualification and chatter sequences.
module tb_debounce_moore;

`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic in_clk;
    logic in_rst;
    logic in_i;
    logic o_q;
    logic o_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic in_v;
        logic exp_q;
        logic exp_busy;
    } vec_t;

    vec_t vecs[$];

    debounce_moore #(.STABLE_CYCLES(4)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_i   (in_i),
        .o_q    (o_q),
        .o_busy (o_busy)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic add_n(input int n, input logic i_v, input logic q_v, input logic b_v);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v.in_v     = i_v;
            v.exp_q    = q_v;
            v.exp_busy = b_v;
            vecs.push_back(v);
        end
    endtask

    task automatic step(input logic rst_v, input logic i_v);
        in_rst = rst_v;
        in_i   = i_v;
        @(posedge in_clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int   n_edges;
        int   n_busy;
        int   toggles;
        logic prev_q;
        logic eq;
        logic eb;

        // Per-cycle vectors for a synchronous input: in_i before the edge, outputs after it.
        add_n(10, 1'b0, 1'b0, 1'b0);   // idle low
        add_n(3,  1'b1, 1'b0, 1'b1);   // rise qualification
        add_n(1,  1'b1, 1'b1, 1'b0);   // accepted on 4th sample
        add_n(2,  1'b1, 1'b1, 1'b0);
        add_n(1,  1'b0, 1'b1, 1'b1);   // 1-cycle low blip
        add_n(1,  1'b1, 1'b1, 1'b0);   // aborted, q stays high
        add_n(1,  1'b1, 1'b1, 1'b0);
        add_n(3,  1'b0, 1'b1, 1'b1);   // fall qualification
        add_n(1,  1'b0, 1'b0, 1'b0);
        add_n(2,  1'b0, 1'b0, 1'b0);
        add_n(3,  1'b1, 1'b0, 1'b1);   // 3-sample glitch
        add_n(1,  1'b0, 1'b0, 1'b0);   // abort at terminal-count edge
        add_n(1,  1'b0, 1'b0, 1'b0);
        add_n(3,  1'b1, 1'b0, 1'b1);   // clean 4-sample high
        add_n(1,  1'b1, 1'b1, 1'b0);
        add_n(1,  1'b1, 1'b1, 1'b0);
        add_n(3,  1'b0, 1'b1, 1'b1);
        add_n(1,  1'b0, 1'b0, 1'b0);
        add_n(3,  1'b0, 1'b0, 1'b0);

        in_rst = 1'b1;
        in_i   = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_bit("reset_q", o_q, 1'b0);
        check_bit("reset_busy", o_busy, 1'b0);

        // The synchronizer build sees the same sample stream SYNC_LAT edges later.
        for (int k = 0; k < vecs.size(); k++) begin
            step(1'b0, vecs[k].in_v);
            if (k >= SYNC_LAT) begin
                eq = vecs[k - SYNC_LAT].exp_q;
                eb = vecs[k - SYNC_LAT].exp_busy;
            end else begin
                eq = 1'b0;
                eb = 1'b0;
            end
            $display("vec %0d: in=%b q=%b busy=%b exp_q=%b exp_busy=%b",
                     k, vecs[k].in_v, o_q, o_busy, eq, eb);
            check_bit($sformatf("vec%0d_q", k), o_q, eq);
            check_bit($sformatf("vec%0d_busy", k), o_busy, eb);
        end

        // Reset while in WAIT_HI with cnt=2 and input held high.
        step(1'b1, 1'b0);
        for (int k = 0; k < 2 + SYNC_LAT; k++) step(1'b0, 1'b1);
        $display("midreset: pre-reset q=%b busy=%b", o_q, o_busy);
        check_bit("midreset_pre_busy", o_busy, 1'b1);
        check_bit("midreset_pre_q", o_q, 1'b0);
        step(1'b1, 1'b1);
        $display("midreset: after reset edge q=%b busy=%b", o_q, o_busy);
        check_bit("midreset_q", o_q, 1'b0);
        check_bit("midreset_busy", o_busy, 1'b0);
        n_edges = 0;
        n_busy  = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b1);
            if (o_busy) n_busy++;
            if (o_q) begin
                n_edges = k;
                break;
            end
        end
        $display("midreset: requalified after %0d edges, busy %0d cycles", n_edges, n_busy);
        check_int("requal_edges", n_edges, 4 + SYNC_LAT);
        check_int("requal_busy_cycles", n_busy, 3);

        // Chatter from high: downstream edge detector must see no transition.
        prev_q  = o_q;
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k % 2 == 0) ? 1'b0 : 1'b1);
            if (o_q !== prev_q) toggles++;
            prev_q = o_q;
        end
        for (int k = 0; k < SYNC_LAT + 2; k++) begin
            step(1'b0, 1'b1);
            if (o_q !== prev_q) toggles++;
            prev_q = o_q;
        end
        $display("chatter_hi: toggles=%0d q=%b", toggles, o_q);
        check_int("chatter_hi_toggles", toggles, 0);
        check_bit("chatter_hi_q", o_q, 1'b1);

        for (int k = 0; k < 4 + SYNC_LAT + 2; k++) step(1'b0, 1'b0);
        check_bit("settle_lo_q", o_q, 1'b0);

        // Chatter from low.
        prev_q  = o_q;
        toggles = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k % 2 == 0) ? 1'b1 : 1'b0);
            if (o_q !== prev_q) toggles++;
            prev_q = o_q;
        end
        for (int k = 0; k < SYNC_LAT + 2; k++) begin
            step(1'b0, 1'b0);
            if (o_q !== prev_q) toggles++;
            prev_q = o_q;
        end
        $display("chatter_lo: toggles=%0d q=%b busy=%b", toggles, o_q, o_busy);
        check_int("chatter_lo_toggles", toggles, 0);
        check_bit("chatter_lo_q", o_q, 1'b0);
        check_bit("chatter_lo_busy", o_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
